uart_tx_serializer: RTL

UART transmitter for the APB-UART subsystem: accepts parallel bytes over a valid/ready handshake and serialises them LSB-first onto `tx`. Each frame is a start bit, data bits, optional parity and one or two stop bits. A one-entry holding register lets the next byte be accepted during a frame, so frames go back-to-back with no idle gap. Bit period is a fixed number of `clk` cycles; the default of 8 matches the subsystem's receiver bit timing.

---
 rtl/uart_tx_serializer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// LSB-first framing with optional parity and one or two stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int TIMER_W  = $clog2(CLKS_PER_BIT);
  localparam int BITCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BITCNT_W-1:0] BIT_LAST   = BITCNT_W'(DATA_BITS - 1);
  localparam logic                STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [DATA_BITS-1:0]  hold_q;
  logic                  hold_full;
  logic                  load;
  logic                  bit_end;
  logic                  tx_d;
  logic                  done_d;
  logic                  tx_q, busy_q, done_q;

  assign bit_end  = (timer_q == TIMER_LAST);
  assign tx_ready = !hold_full;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    load       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (hold_full) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d   = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = PARITY_EN ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          timer_d    = '0;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (stop_cnt_q == STOP_LAST) begin
            done_d = 1'b1;
            // A byte already held starts its frame on this same edge.
            if (hold_full) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (load) begin
      shift_d   = hold_q;
      parity_d  = (^hold_q) ^ PARITY_ODD;
      bit_cnt_d = '0;
    end

    // The line value is decided from the next state so tx is a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      hold_full  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      if (load) begin
        hold_full <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
      end
    end
  end

  // NOTE: pure data registers carry no reset; their contents are only
  // consumed after a qualifying flag (hold_full, load) has been set.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (tx_valid && tx_ready) begin
      hold_q <= tx_data;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
